// File: rtl/jtag_scan_sequencer.sv
// JTAG master: walks the TAP through Test-Logic-Reset or a complete IR/DR scan,
// driving registered TMS/TDI and capturing TDO bit-serially into DataOut.
module jtag_scan_sequencer #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic               TCK,
    input  logic               TRST_N,
    input  logic               Start,
    input  logic               ScanIR,
    input  logic               ResetTap,
    input  logic [LEN_W-1:0]   Len,
    input  logic [MAX_LEN-1:0] DataIn,
    input  logic               TDO,
    output logic               TMS,
    output logic               TDI,
    output logic               Busy,
    output logic               Done,
    output logic [MAX_LEN-1:0] DataOut
);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] TLR_LAST = LEN_W'(5);
    localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};

    typedef enum logic [3:0] {
        ST_TLR     = 4'd0,
        ST_IDLE    = 4'd1,
        ST_SEL_DR  = 4'd2,
        ST_SEL_IR  = 4'd3,
        ST_CAPTURE = 4'd4,
        ST_SHIFT   = 4'd5,
        ST_EXIT1   = 4'd6,
        ST_UPDATE  = 4'd7,
        ST_FINISH  = 4'd8
    } state_t;

    state_t             state_r, state_s;
    logic [LEN_W-1:0]   cnt_r, cnt_s;
    logic [LEN_W-1:0]   len_r, len_s;
    logic [MAX_LEN-1:0] data_r, data_s;
    logic [MAX_LEN-1:0] dout_r, dout_s;
    logic               ir_r, ir_s;
    logic               tlr_req_r, tlr_req_s;
    logic               tms_r, tms_s;
    logic               tdi_r, tdi_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;

    // Next state, request latching and TDO capture
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        len_s     = len_r;
        data_s    = data_r;
        dout_s    = dout_r;
        ir_s      = ir_r;
        tlr_req_s = tlr_req_r;
        case (state_r)
            ST_TLR: begin
                if (cnt_r == TLR_LAST) begin
                    cnt_s     = CNT_ZERO;
                    tlr_req_s = 1'b0;
                    // Only a requested walk reports completion; a TRST_N walk does not
                    if (tlr_req_r) state_s = ST_FINISH;
                    else           state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_IDLE, ST_FINISH: begin
                cnt_s = CNT_ZERO;
                if (ResetTap) begin
                    state_s   = ST_TLR;
                    tlr_req_s = 1'b1;
                end else if (Start && (Len == CNT_ZERO)) begin
                    state_s = ST_FINISH;
                end else if (Start) begin
                    state_s = ST_SEL_DR;
                    ir_s    = ScanIR;
                    len_s   = (Len > LEN_MAX) ? LEN_MAX : Len;
                    data_s  = DataIn;
                    dout_s  = {MAX_LEN{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEL_DR: begin
                if (ir_r) state_s = ST_SEL_IR;
                else      state_s = ST_CAPTURE;
            end
            ST_SEL_IR: state_s = ST_CAPTURE;
            // Two TMS=0 cycles: one enters Capture, the next moves the TAP into Shift
            ST_CAPTURE: begin
                if (cnt_r == CNT_ONE) begin
                    cnt_s   = CNT_ZERO;
                    state_s = ST_SHIFT;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_SHIFT: begin
                dout_s[cnt_r[IDX_W-1:0]] = TDO;
                if (cnt_r == (len_r - CNT_ONE)) begin
                    cnt_s   = CNT_ZERO;
                    state_s = ST_EXIT1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_EXIT1:  state_s = ST_UPDATE;
            ST_UPDATE: state_s = ST_FINISH;
            default: begin
                state_s   = ST_TLR;
                cnt_s     = CNT_ZERO;
                tlr_req_s = 1'b0;
            end
        endcase
    end

    // Pin values for the state being entered, so TMS/TDI/Busy/Done leave flops
    always_comb begin
        tms_s = 1'b0;
        tdi_s = 1'b0;
        case (state_s)
            ST_TLR: begin
                if (cnt_s == TLR_LAST) tms_s = 1'b0;
                else                   tms_s = 1'b1;
            end
            ST_SEL_DR, ST_SEL_IR, ST_EXIT1: tms_s = 1'b1;
            ST_SHIFT: begin
                tdi_s = data_s[cnt_s[IDX_W-1:0]];
                if (cnt_s == (len_s - CNT_ONE)) tms_s = 1'b1;
                else                            tms_s = 1'b0;
            end
            ST_IDLE, ST_CAPTURE, ST_UPDATE, ST_FINISH: tms_s = 1'b0;
            default: tms_s = 1'b0;
        endcase
        if ((state_s == ST_IDLE) || (state_s == ST_FINISH)) busy_s = 1'b0;
        else                                                busy_s = 1'b1;
        done_s = (state_s == ST_FINISH);
    end

    // State, datapath and output registers
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            state_r   <= ST_TLR;
            cnt_r     <= CNT_ZERO;
            len_r     <= CNT_ZERO;
            data_r    <= {MAX_LEN{1'b0}};
            dout_r    <= {MAX_LEN{1'b0}};
            ir_r      <= 1'b0;
            tlr_req_r <= 1'b0;
            tms_r     <= 1'b1;
            tdi_r     <= 1'b0;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            len_r     <= len_s;
            data_r    <= data_s;
            dout_r    <= dout_s;
            ir_r      <= ir_s;
            tlr_req_r <= tlr_req_s;
            tms_r     <= tms_s;
            tdi_r     <= tdi_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign TMS     = tms_r;
    assign TDI     = tdi_r;
    assign Busy    = busy_r;
    assign Done    = done_r;
    assign DataOut = dout_r;

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Bench: sequencer drives a behavioural 16-state TAP whose TDO is a bypass flop
// (captures 0); scans come from a vector table, hand sequences and random requests.
module tb_jtag_scan_sequencer;
    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                   PAUDR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10,
                   SHIR = 11, EX1IR = 12, PAUIR = 13, EX2IR = 14, UPIR = 15;

    logic        TCK = 1'b0;
    logic        TRST_N, Start, ScanIR, ResetTap, TDO, TMS, TDI, Busy, Done;
    logic [5:0]  Len;
    logic [31:0] DataIn, DataOut;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_dout = 32'h0;

    typedef struct {
        logic        ir;
        logic [5:0]  len;
        logic [31:0] data;
        logic [31:0] dout;
        int          lat;
    } vec_t;
    vec_t vecs[8];

    always #5 TCK = ~TCK;

    jtag_scan_sequencer dut (
        .TCK(TCK), .TRST_N(TRST_N), .Start(Start), .ScanIR(ScanIR),
        .ResetTap(ResetTap), .Len(Len), .DataIn(DataIn), .TDO(TDO),
        .TMS(TMS), .TDI(TDI), .Busy(Busy), .Done(Done), .DataOut(DataOut)
    );

    // Target TAP: starts in an arbitrary state (Shift-DR), not reset by TRST_N
    int   tap_state  = SHDR;
    int   tlr_visits = 0;
    logic bp         = 1'b0;
    assign TDO = bp;

    function automatic int tap_next(input int s, input logic t);
        case (s)
            TLR:   return t ? TLR   : RTI;
            RTI:   return t ? SELDR : RTI;
            SELDR: return t ? SELIR : CAPDR;
            CAPDR: return t ? EX1DR : SHDR;
            SHDR:  return t ? EX1DR : SHDR;
            EX1DR: return t ? UPDR  : PAUDR;
            PAUDR: return t ? EX2DR : PAUDR;
            EX2DR: return t ? UPDR  : SHDR;
            UPDR:  return t ? SELDR : RTI;
            SELIR: return t ? TLR   : CAPIR;
            CAPIR: return t ? EX1IR : SHIR;
            SHIR:  return t ? EX1IR : SHIR;
            EX1IR: return t ? UPIR  : PAUIR;
            PAUIR: return t ? EX2IR : PAUIR;
            EX2IR: return t ? UPIR  : SHIR;
            UPIR:  return t ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    always @(posedge TCK) begin
        if (tap_state == CAPDR || tap_state == CAPIR) bp <= 1'b0;
        else if (tap_state == SHDR || tap_state == SHIR) bp <= TDI;
        tap_state <= tap_next(tap_state, TMS);
        if (tap_next(tap_state, TMS) == TLR) tlr_visits <= tlr_visits + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the sequencer idle or finishing
    task automatic check_scan(input logic ir, input logic [5:0] len, input logic [31:0] data,
                              input logic [31:0] exp_dout, input int exp_lat,
                              input bit hold, input bit pulse_busy, input string name);
        int ls, j, k, nsh, done_j;
        logic [63:0] exp_tms, obs_tms, obs_tdi, mask;
        bit busy_ok;
        ls      = (len > 6'd32) ? 32 : int'(len);
        mask    = (64'd1 << ls) - 64'd1;
        exp_tms = 64'd0;
        k       = 0;
        if (ls != 0) begin
            exp_tms[k] = 1'b1; k++;
            if (ir) begin exp_tms[k] = 1'b1; k++; end
            k += 2 + ls - 1;
            exp_tms[k] = 1'b1; k++;
            exp_tms[k] = 1'b1;
        end
        obs_tms = 64'd0;
        obs_tdi = 64'd0;
        nsh     = 0;
        busy_ok = 1'b1;
        done_j  = exp_lat + 1;
        Start = 1'b1; ScanIR = ir; Len = len; DataIn = data; ResetTap = 1'b0;
        j = 0;
        while (j < done_j + 20) begin
            @(negedge TCK);
            j++;
            if (j == 1 && !hold) Start = 1'b0;
            if (pulse_busy && j == 3) begin Start = 1'b1; ResetTap = 1'b1; Len = 6'd2; end
            if (pulse_busy && j == 4) begin Start = 1'b0; ResetTap = 1'b0; Len = len; end
            if (Done) break;
            if (!Busy) busy_ok = 1'b0;
            obs_tms[j-1] = TMS;
            if ((tap_state == SHDR || tap_state == SHIR) && nsh < 63) begin
                obs_tdi[nsh] = TDI;
                nsh++;
            end
        end
        chk({name, " latency"}, 64'(j - 1), 64'(exp_lat));
        chk({name, " tms"}, obs_tms, exp_tms);
        chk({name, " shift_cycles"}, 64'(nsh), 64'(ls));
        chk({name, " tdi"}, obs_tdi, 64'(data) & mask);
        chk({name, " busy_during"}, 64'(busy_ok), 64'd1);
        chk({name, " dataout"}, 64'(DataOut), 64'(exp_dout));
        chk({name, " busy_at_done"}, 64'(Busy), 64'd0);
        chk({name, " tap_rti"}, 64'(tap_state), 64'(RTI));
        model_dout = exp_dout;
    endtask

    task automatic idle_check(input int n, input string name);
        Start = 1'b0; ResetTap = 1'b0;
        repeat (n) begin
            @(negedge TCK);
            chk({name, " busy"}, 64'(Busy), 64'd0);
            chk({name, " done"}, 64'(Done), 64'd0);
            chk({name, " tms"}, 64'(TMS), 64'd0);
        end
    endtask

    // Called at a negedge while TRST_N is low
    task automatic reset_walk(input int v0, input string name);
        logic [63:0] obs;
        bit busy_ok, done_seen;
        obs = 64'd0; busy_ok = 1'b1; done_seen = 1'b0;
        TRST_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            obs[i] = TMS;
            if (!Busy) busy_ok = 1'b0;
            if (Done) done_seen = 1'b1;
            @(negedge TCK);
        end
        chk({name, " walk_tms"}, obs, 64'h1F);
        chk({name, " walk_busy"}, 64'(busy_ok), 64'd1);
        chk({name, " idle_busy"}, 64'(Busy), 64'd0);
        chk({name, " idle_tms"}, 64'(TMS), 64'd0);
        for (int i = 0; i < 3; i++) begin
            if (Done) done_seen = 1'b1;
            @(negedge TCK);
        end
        chk({name, " no_done"}, 64'(done_seen), 64'd0);
        chk({name, " tap_saw_tlr"}, 64'(tlr_visits > v0), 64'd1);
        chk({name, " tap_rti"}, 64'(tap_state), 64'(RTI));
    endtask

    task automatic check_tlr(input bit with_start, input string name);
        int v0, j;
        logic [63:0] obs;
        bit busy_ok;
        v0 = tlr_visits; obs = 64'd0; busy_ok = 1'b1; j = 0;
        ResetTap = 1'b1; Start = with_start; ScanIR = 1'b0; Len = 6'd8; DataIn = 32'hFFFF_FFFF;
        while (j < 30) begin
            @(negedge TCK);
            j++;
            if (j == 1) begin ResetTap = 1'b0; Start = 1'b0; end
            if (Done) break;
            if (!Busy) busy_ok = 1'b0;
            obs[j-1] = TMS;
        end
        chk({name, " latency"}, 64'(j - 1), 64'd6);
        chk({name, " tms"}, obs, 64'h1F);
        chk({name, " busy_during"}, 64'(busy_ok), 64'd1);
        chk({name, " tap_saw_tlr"}, 64'(tlr_visits > v0), 64'd1);
        chk({name, " tap_rti"}, 64'(tap_state), 64'(RTI));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ls, lat, nsh, v0;
        logic ir;
        logic [5:0] len;
        logic [31:0] data, dout;

        vecs[0] = '{1'b1, 6'd4,  32'h0000_000A, 32'h0000_0004, 10};
        vecs[1] = '{1'b0, 6'd8,  32'h0000_00A5, 32'h0000_004A, 13};
        vecs[2] = '{1'b0, 6'd0,  32'h0000_FFFF, 32'h0000_004A, 0};
        vecs[3] = '{1'b0, 6'd40, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 37};
        vecs[4] = '{1'b0, 6'd32, 32'h8000_0001, 32'h0000_0002, 37};
        vecs[5] = '{1'b0, 6'd1,  32'h0000_0001, 32'h0000_0000, 6};
        vecs[6] = '{1'b1, 6'd1,  32'h0000_0001, 32'h0000_0000, 7};
        vecs[7] = '{1'b1, 6'd5,  32'h0000_001F, 32'h0000_001E, 11};

        TRST_N = 1'b0; Start = 1'b0; ScanIR = 1'b0; ResetTap = 1'b0;
        Len = 6'd0; DataIn = 32'h0;
        repeat (3) @(negedge TCK);
        chk("reset tms", 64'(TMS), 64'd1);
        chk("reset tdi", 64'(TDI), 64'd0);
        chk("reset busy", 64'(Busy), 64'd1);
        chk("reset done", 64'(Done), 64'd0);
        chk("reset dataout", 64'(DataOut), 64'd0);
        reset_walk(0, "por");

        for (int i = 0; i < 8; i++)
            check_scan(vecs[i].ir, vecs[i].len, vecs[i].data, vecs[i].dout, vecs[i].lat,
                       1'b0, 1'b0, $sformatf("vec%0d", i));
        idle_check(3, "idle_after_vecs");

        check_scan(1'b0, 6'd8, 32'h3C, 32'h78, 13, 1'b0, 1'b1, "busy_pulse");
        idle_check(4, "not_queued");

        check_scan(1'b1, 6'd3, 32'h5, 32'h2, 9, 1'b1, 1'b0, "held_first");
        check_scan(1'b0, 6'd6, 32'h2B, 32'h16, 11, 1'b0, 1'b0, "held_second");
        idle_check(2, "idle_after_held");

        check_tlr(1'b1, "tlr_with_start");
        idle_check(2, "idle_after_tlr");
        check_tlr(1'b0, "tlr_only");

        for (int i = 0; i < 24; i++) begin
            ir   = 1'($urandom_range(0, 1));
            len  = 6'($urandom_range(0, 40));
            data = $urandom;
            ls   = (len > 6'd32) ? 32 : int'(len);
            lat  = (ls == 0) ? 0 : ls + 5 + int'(ir);
            dout = (ls == 0) ? model_dout : 32'((64'(data) << 1) & ((64'd1 << ls) - 64'd1));
            check_scan(ir, len, data, dout, lat, 1'b0, 1'b0, $sformatf("rnd%0d", i));
            idle_check($urandom_range(0, 2), $sformatf("rnd_idle%0d", i));
        end

        Start = 1'b1; ScanIR = 1'b0; Len = 6'd8; DataIn = 32'hFF; ResetTap = 1'b0;
        nsh = 0;
        for (int j = 1; j < 40; j++) begin
            @(negedge TCK);
            if (j == 1) Start = 1'b0;
            if (tap_state == SHDR) begin
                if (nsh == 3) break;
                nsh++;
            end
        end
        chk("midshift reached_bit3", 64'(nsh), 64'd3);
        chk("midshift partial_dataout", 64'(DataOut), 64'h6);
        v0 = tlr_visits;
        TRST_N = 1'b0;
        #1;
        chk("midshift rst tms", 64'(TMS), 64'd1);
        chk("midshift rst busy", 64'(Busy), 64'd1);
        chk("midshift rst dataout", 64'(DataOut), 64'd0);
        chk("midshift rst done", 64'(Done), 64'd0);
        chk("midshift rst tdi", 64'(TDI), 64'd0);
        repeat (2) @(negedge TCK);
        reset_walk(v0, "midshift");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
